// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the HD44780 command driver
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } lcd_state_e;

    localparam int LCD_ON_BIT   = 31;
    localparam int LCD_STRB_BIT = 10;
    localparam int LCD_RS_BIT   = 9;

    // Clear display and return home need the long execution time; 0x03 is home with a don't-care bit.
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME || data == LCD_CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - command queue; a push while full is accepted when a pop happens in the same cycle
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/lcd_cmd_driver.sv
// rtl/lcd_cmd_driver.sv - queues LSU writes to the LCD register and replays them as timed HD44780 bus cycles
module lcd_cmd_driver
    import lcd_pkg::*;
#(
    parameter int T_SETUP    = 4,
    parameter int T_EN       = 25,
    parameter int T_HOLD     = 4,
    parameter int T_EXEC     = 2000,
    parameter int T_LONG     = 82000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lcd_word,
    output logic        o_lcd_on,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic        o_overflow
);

    localparam int CNT_W = $clog2(T_LONG + 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             strb_q, arm_q, lcd_on_q, overflow_q;
    logic             capture, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [8:0]       fifo_rdata;
    logic             unused_word;

    assign unused_word = ^{i_lcd_word[30:11], i_lcd_word[8]};

    // arm_q masks the first cycle out of reset so a strobe already high is not seen as an edge.
    assign capture = arm_q & i_lcd_word[LCD_STRB_BIT] & ~strb_q & i_lcd_word[LCD_ON_BIT];
    assign drop    = capture & fifo_full & ~pop;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push_i  (capture),
        .wdata_i ({i_lcd_word[LCD_RS_BIT], i_lcd_word[7:0]}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop            = 1'b1;
                    {rs_d, data_d} = fifo_rdata;
                    cnt_d          = CNT_W'(T_SETUP - 1);
                    state_d        = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(T_EN - 1);
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(T_HOLD - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = is_long_cmd(rs_q, data_q) ? CNT_W'(T_LONG - 1) : CNT_W'(T_EXEC - 1);
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            strb_q     <= 1'b0;
            arm_q      <= 1'b0;
            lcd_on_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            strb_q     <= i_lcd_word[LCD_STRB_BIT];
            arm_q      <= 1'b1;
            lcd_on_q   <= i_lcd_word[LCD_ON_BIT];
            overflow_q <= overflow_q | drop;
        end
    end

    // EN decodes straight from the async-reset state register, so reset drops it without a clock.
    assign o_lcd_en   = (state_q == ST_PULSE);
    assign o_lcd_on   = lcd_on_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_q;
    assign o_busy     = (state_q != ST_IDLE) | ~fifo_empty;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// tb/tb_lcd_cmd_driver.sv - self-checking bench for lcd_cmd_driver
module tb_lcd_cmd_driver;

    localparam int T_SETUP = 2;
    localparam int T_EN    = 3;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 10;
    localparam int T_LONG  = 30;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_lcd_word = 32'h0;
    logic        o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_busy, o_overflow;
    logic [7:0]  o_lcd_data;

    int n_chk = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];
    int en_rises = 0;
    logic en_prev = 1'b0;
    int en_len = 0;

    typedef struct {
        logic [31:0] word;
        logic        rs;
        logic [7:0]  data;
        int          wait_cyc;
    } vec_t;
    vec_t vecs[8];

    lcd_cmd_driver #(
        .T_SETUP    (T_SETUP),
        .T_EN       (T_EN),
        .T_HOLD     (T_HOLD),
        .T_EXEC     (T_EXEC),
        .T_LONG     (T_LONG),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_lcd_word (i_lcd_word),
        .o_lcd_on   (o_lcd_on),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_data (o_lcd_data),
        .o_busy     (o_busy),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every EN rise must present the oldest expected {RS,DATA}; every EN pulse is T_EN long.
    always @(negedge i_clk) begin
        if (i_rst) begin
            en_prev = 1'b0;
            en_len  = 0;
        end else begin
            if (o_lcd_en) begin
                if (!en_prev) begin
                    en_rises++;
                    if (exp_q.size() == 0) check("sb_unexpected_en", o_lcd_en, 1'b0);
                    else                   check("sb_data", {o_lcd_rs, o_lcd_data}, exp_q.pop_front());
                end
                en_len++;
            end else if (en_prev) begin
                check("en_width", en_len, T_EN);
                en_len = 0;
            end
            en_prev = o_lcd_en;
        end
    end

    task automatic strobe(input logic [31:0] w, input bit accept);
        i_lcd_word = w | 32'h0000_0400;
        if (accept) exp_q.push_back({w[9], w[7:0]});
        @(negedge i_clk);
        i_lcd_word = w & ~32'h0000_0400;
        @(negedge i_clk);
    endtask

    task automatic wait_en(input logic lvl, input int max, input string name, output int n);
        n = 0;
        while (o_lcd_en !== lvl && n < max) begin
            @(negedge i_clk);
            n++;
        end
        check(name, o_lcd_en, lvl);
    endtask

    task automatic wait_idle(input int max, input string name, output int n);
        n = 0;
        while (o_busy !== 1'b0 && n < max) begin
            @(negedge i_clk);
            n++;
        end
        check(name, o_busy, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, rises0;

        vecs[0] = '{32'h8000_0241, 1'b1, 8'h41, T_EXEC};
        vecs[1] = '{32'h8000_0001, 1'b0, 8'h01, T_LONG};
        vecs[2] = '{32'h8000_0002, 1'b0, 8'h02, T_LONG};
        vecs[3] = '{32'h8000_0103, 1'b0, 8'h03, T_LONG};
        vecs[4] = '{32'h8000_0004, 1'b0, 8'h04, T_EXEC};
        vecs[5] = '{32'h8000_0201, 1'b1, 8'h01, T_EXEC};
        vecs[6] = '{32'h8000_7880, 1'b0, 8'h80, T_EXEC};
        vecs[7] = '{32'h8000_0200, 1'b1, 8'h00, T_EXEC};

        repeat (3) @(negedge i_clk);
        check("rst_on", o_lcd_on, 1'b0);
        check("rst_rs", o_lcd_rs, 1'b0);
        check("rst_en", o_lcd_en, 1'b0);
        check("rst_data", o_lcd_data, 8'h00);
        check("rst_busy", o_busy, 1'b0);
        check("rst_ovf", o_overflow, 1'b0);
        check("rst_rw", o_lcd_rw, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Power gate: strobes with LCD_ON clear must be ignored.
        rises0 = en_rises;
        for (int i = 0; i < 3; i++) strobe(32'h0000_0255 + 32'(i), 1'b0);
        repeat (20) @(negedge i_clk);
        check("gate_en_count", en_rises, rises0);
        check("gate_busy", o_busy, 1'b0);
        check("gate_on", o_lcd_on, 1'b0);

        // Single data write: RS/DATA visible in SETUP, busy clears 17 cycles after the pop.
        strobe(32'h8000_0241, 1'b1);
        check("single_setup_rs", o_lcd_rs, 1'b1);
        check("single_setup_data", o_lcd_data, 8'h41);
        check("single_setup_en", o_lcd_en, 1'b0);
        check("single_on", o_lcd_on, 1'b1);
        wait_idle(100, "single_idle", k);
        check("single_busy_cycles", k, T_SETUP + T_EN + T_HOLD + T_EXEC);

        for (int i = 0; i < 8; i++) begin
            strobe(vecs[i].word, 1'b1);
            wait_en(1'b1, 10, "vec_en_rise", n);
            wait_en(1'b0, 10, "vec_en_fall", n);
            wait_idle(200, "vec_idle", k);
            check("vec_fall_to_idle", k, T_HOLD + vecs[i].wait_cyc);
            check("vec_rs_held", o_lcd_rs, vecs[i].rs);
            check("vec_data_held", o_lcd_data, vecs[i].data);
            check("vec_rw", o_lcd_rw, 1'b0);
        end

        // Clear followed by a queued command: fall-to-next-rise spans HOLD+WAIT+IDLE+SETUP.
        strobe(32'h8000_0001, 1'b1);
        strobe(32'h8000_0030, 1'b1);
        wait_en(1'b1, 10, "clr_rise", n);
        wait_en(1'b0, 10, "clr_fall", n);
        wait_en(1'b1, 100, "clr_next_rise", k);
        check("clr_fall_to_rise", k, T_HOLD + T_LONG + 1 + T_SETUP);
        wait_idle(100, "clr_idle", k);

        // Overflow: one in service, four queued, the sixth dropped; order checked by the scoreboard.
        for (int i = 0; i < 6; i++) begin
            strobe(32'h8000_0010 + 32'(i), i < 5);
            if (i == 4) check("ovf_before_drop", o_overflow, 1'b0);
        end
        check("ovf_set", o_overflow, 1'b1);
        wait_idle(600, "ovf_idle", k);
        check("ovf_sb_drained", exp_q.size(), 0);
        check("ovf_sticky", o_overflow, 1'b1);

        // Reset in the second EN-high cycle, strobe held high across reset release.
        i_lcd_word = 32'h8000_0455;
        exp_q.push_back(9'h055);
        wait_en(1'b1, 10, "rstp_rise", n);
        @(negedge i_clk);
        check("rstp_en_before", o_lcd_en, 1'b1);
        i_rst = 1'b1;
        #1;
        check("rstp_en_async", o_lcd_en, 1'b0);
        check("rstp_busy", o_busy, 1'b0);
        check("rstp_ovf", o_overflow, 1'b0);
        check("rstp_data", o_lcd_data, 8'h00);
        check("rstp_on", o_lcd_on, 1'b0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        rises0 = en_rises;
        repeat (40) @(negedge i_clk);
        check("rstp_no_issue", en_rises, rises0);
        check("rstp_busy_after", o_busy, 1'b0);
        check("rstp_on_after", o_lcd_on, 1'b1);
        check("rstp_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
